// File: rtl/pp_row_accumulator.sv
// pp_row_accumulator: serial partial-product row accumulator.
// Sums WIDTH shifted rows into a 2*WIDTH-bit unsigned product.
module pp_row_accumulator #(
  parameter int WIDTH = 16,
  parameter int CW    = 5
) (
  input  logic               clk,
  input  logic               rst,
  output logic [CW-1:0]      row_sel,
  input  logic               row_valid,
  output logic               row_ready,
  input  logic [WIDTH-1:0]   row_data,
  output logic               prod_valid,
  input  logic               prod_ready,
  output logic [2*WIDTH-1:0] prod_data,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] acc_q;
  logic [PW-1:0] acc_d;
  logic [CW-1:0] sel_q;
  logic [CW-1:0] sel_d;
  logic          busy_q;
  logic          busy_d;

  logic [PW-1:0] row_ext;
  logic [PW-1:0] row_shift;
  logic [CW-1:0] shamt;
  logic          row_fire;
  logic          last_row;

  // Row k lands at weight 2^(k-1); shift range is 0..WIDTH-1.
  assign shamt     = sel_q - CW'(1);
  assign row_ext   = {{WIDTH{1'b0}}, row_data};
  assign row_shift = row_ext << shamt;

  assign row_ready = (state_q == ACCUM);
  assign row_fire  = row_valid && row_ready;
  assign last_row  = (sel_q == CW'(WIDTH));

  assign prod_valid = (state_q == DONE);
  assign prod_data  = acc_q;
  assign row_sel    = sel_q;
  assign busy       = busy_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      sel_q   <= CW'(1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: accumulate rows, then hold product until taken.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    unique case (state_q)
      ACCUM: begin
        if (row_fire) begin
          acc_d = acc_q + row_shift;
          if (last_row) begin
            state_d = DONE;
            sel_d   = CW'(1);
            busy_d  = 1'b0;
          end else begin
            sel_d  = sel_q + CW'(1);
            busy_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (prod_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

endmodule

// File: doc/pp_row_accumulator.md
Name: pp_row_accumulator

Overview:
- Sequential consumer of partial-product rows for the 16-bit multiplier datapath.
- Indicates which multiplier bit the upstream AND stage must use. Accepts one WIDTH-bit row (A & B[k]) per handshake and adds it into the product at weight 2^(k-1).
- After WIDTH rows, presents the 2*WIDTH-bit unsigned product on a valid/ready output.
- Serves as the low-area alternative to the Wallace reduction tree; it is the receiving end of the partial-product row interface.

Parameters:
- WIDTH, 16, operand width and number of rows per product (must be >= 2).
- CW, 5, row-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- row_sel  output  CW  index k (1..WIDTH) of the row currently expected; upstream drives row_data = A & B[k]
- row_valid  input  1  row_data holds a valid row for row_sel
- row_ready  output  1  block can accept a row this cycle
- row_data  input  WIDTH  partial-product row
- prod_valid  output  1  prod_data holds a completed product
- prod_ready  input  1  downstream accepts the product
- prod_data  output  2*WIDTH  accumulated unsigned product
- busy  output  1  at least one row of the current product has been accepted, and the product is not yet complete

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge.
- Reset values: state=ACCUM, accumulator=0, row_sel=1, row_ready=1, prod_valid=0, prod_data=0, busy=0.
- Reset mid-operation: asserting rst in any state discards the partial sum and any pending product; no output handshake occurs.
- States: ACCUM and DONE.
- ACCUM:
  - row_ready=1 and prod_valid=0.
  - On row accept (row_valid & row_ready): acc <= acc + (zero-extended row_data << (row_sel-1)), computed modulo 2^(2*WIDTH). No overflow is possible.
  - If row_sel < WIDTH on accept: row_sel <= row_sel+1 and busy <= 1.
  - If row_sel == WIDTH on accept: go to DONE, row_sel <= 1, busy <= 0.
  - row_valid=0: hold all state; gaps of any length are legal.
- DONE:
  - prod_valid=1, row_ready=0, and prod_data = final accumulator.
  - prod_data and prod_valid stay stable until prod_ready=1.
  - On prod_ready=1: prod_valid <= 0, acc <= 0, return to ACCUM.
  - row_valid is ignored in DONE; no row is consumed.
  - Consequence: there is one bubble cycle between products.
- Latency:
  - Product is valid on the cycle after the WIDTH-th row accept.
  - Minimum product-to-product period is WIDTH+1 cycles when prod_ready is held at 1.
- Boundary rules:
  - row_sel counts 1..WIDTH, then wraps back to 1.
  - row_sel and row_data must not change while row_valid=1 and row_ready=0. This cannot occur in ACCUM.
  - prod_ready asserted while in ACCUM has no effect.
  - prod_data during ACCUM shows the running accumulator, but it is meaningful only when prod_valid=1.
- Arithmetic: unsigned only. The shift amount uses row_sel-1, range 0..WIDTH-1. Adder width is 2*WIDTH.

Test Plan:
- Back-to-back full-scale rows: WIDTH=16, 16 rows of 0xFFFF, row_valid held high, prod_ready=1 -> prod_valid on cycle 17 with prod_data=0xFFFE0001; row_sel sequence 1..16 then 1.
- Sparse rows: A=0x1234, B=0x0003, so rows 1–2 = 0x1234 and rows 3–16 = 0 -> prod_data=0x0000369C; busy=1 after row 1 and busy=0 once DONE is entered.
- Random row_valid gaps: A=0xABCD, B=0x8001, row_valid asserted at random -> prod_data=0x55E72BCD; row_sel advances only on accepted cycles.
- Output backpressure: prod_ready=0 for 5 cycles after completion while row_valid=1 -> prod_valid and prod_data held stable, row_ready=0, no rows consumed. After prod_ready=1 the next product starts from acc=0 with row_sel=1.
- Reset mid-operation: rst asserted after 7 rows -> next cycle row_sel=1, busy=0, prod_valid=0. A following full 0x0002×0x0003 sequence yields prod_data=0x00000006.
- Randomised self-check: 1000 random A,B pairs with random valid/ready -> every prod_data equals A*B mod 2^32, and every product appears exactly once.
